uart_rx_cfg: RTL and testbench

- Parametrised successor to the team's fixed 8N1 byte receiver.
- Runtime-configurable UART receiver with 16x oversampling and a majority vote over 6 samples per bit.
- Supports 5..DATA_W data bits, none/even/odd parity and 1 or 2 stop bits; reports frame, parity, break and overrun conditions.
- Sits between the board RX pin and command-parsing logic; delivers words on a valid/ready handshake with a one-word holding register.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_rx_cfg.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the configurable UART receiver and its baud generator.
package uart_pkg;

  localparam int unsigned OVS   = 16;
  localparam int unsigned SUB_W = 4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [SUB_W-1:0] SAMPLE_FIRST = 4'd6;
  localparam logic [SUB_W-1:0] SAMPLE_LAST  = 4'd11;
  localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(OVS - 1);

  localparam logic [2:0] VOTE_ONE     = 3'd4;
  localparam logic [2:0] START_REJECT = 3'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef struct packed {
    logic frame_err;
    logic parity_err;
    logic break_det;
  } rx_flags_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Prescaler producing one tick per oversample period; shared by the UART RX and TX.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  assign tick_c = enable && !clear && (cnt == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == div) ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 16x oversampling, 6-sample majority vote,
// 5..DATA_W data bits, optional parity, 1/2 stop bits, one-word holding register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [3:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              break_det,
  output logic              overrun,
  output logic              busy
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_d;
  logic                   fall;

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [SUB_W-1:0]  sub;
  logic [2:0]        vote;
  logic [2:0]        vote_now;
  logic              bit_c;
  logic              in_win;
  logic              tick;
  logic              start_c;
  logic              at_mid;
  logic              at_end;

  logic [3:0]        idx;
  logic              stop_idx;
  logic [3:0]        bits_clamp;
  logic [3:0]        bits_q;
  logic [1:0]        par_q;
  logic              par_en;
  logic              stop2_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] shreg;
  logic              fe_q;
  logic              pe_q;
  logic              ones_q;
  rx_flags_t         flags_q;

  assign rx_s    = sync[SYNC_STAGES-1];
  assign fall    = rx_d && !rx_s;
  assign start_c = (state == S_IDLE) && fall;
  assign in_win  = (sub >= SAMPLE_FIRST) && (sub <= SAMPLE_LAST);
  assign vote_now = vote + ((in_win && rx_s) ? 3'd1 : 3'd0);
  assign bit_c   = (vote_now >= VOTE_ONE);
  assign at_mid  = tick && (sub == SAMPLE_LAST);
  assign at_end  = tick && (sub == SUB_LAST);
  assign par_en  = (par_q != PAR_NONE);

  assign frame_err  = flags_q.frame_err;
  assign parity_err = flags_q.parity_err;
  assign break_det  = flags_q.break_det;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_c),
    .enable (state != S_IDLE),
    .div    (div_q),
    .tick_c (tick)
  );

  // Input synchroniser and edge register; idle line is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '1;
      rx_d <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      rx_d <= rx_s;
    end
  end

  always_comb begin
    bits_clamp = cfg_data_bits;
    if (cfg_data_bits < 4'd5) begin
      bits_clamp = 4'd5;
    end else if (cfg_data_bits > 4'(DATA_W)) begin
      bits_clamp = 4'(DATA_W);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (fall) next_state = S_START;
      S_START: begin
        if (at_mid && (vote_now >= START_REJECT)) next_state = S_IDLE;
        else if (at_end)                          next_state = S_DATA;
      end
      S_DATA:   if (at_end && (idx == bits_q - 4'd1)) next_state = par_en ? S_PARITY : S_STOP;
      S_PARITY: if (at_end) next_state = S_STOP;
      // Leave at mid-bit so the next start edge is never missed.
      S_STOP:   if (at_mid && (stop_idx == stop2_q)) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Frame datapath: config capture, sampling, bit assembly and error tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub      <= '0;
      vote     <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      bits_q   <= '0;
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
      div_q    <= '0;
      shreg    <= '0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
      ones_q   <= 1'b0;
    end else if (start_c) begin
      sub      <= '0;
      vote     <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      bits_q   <= bits_clamp;
      par_q    <= ((cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD)) ? cfg_parity : PAR_NONE;
      stop2_q  <= cfg_stop2;
      div_q    <= baud_div;
      shreg    <= '0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
      ones_q   <= 1'b0;
    end else if (tick) begin
      sub  <= sub + 4'd1;
      vote <= (sub == SUB_LAST) ? 3'd0 : vote_now;
      if (sub == SAMPLE_LAST) begin
        case (state)
          S_DATA: begin
            for (int i = 0; i < DATA_W; i++) begin
              if (idx == 4'(i)) shreg[i] <= bit_c;
            end
            ones_q <= ones_q | bit_c;
          end
          S_PARITY: begin
            pe_q   <= bit_c ^ (^shreg) ^ (par_q == PAR_ODD);
            ones_q <= ones_q | bit_c;
          end
          S_STOP: begin
            if (!bit_c) fe_q <= 1'b1;
            ones_q <= ones_q | bit_c;
          end
          default: ;
        endcase
      end
      if (sub == SUB_LAST) begin
        if (state == S_DATA) idx <= idx + 4'd1;
        if (state == S_STOP) stop_idx <= 1'b1;
      end
    end
  end

  // Holding register and valid/ready handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      flags_q  <= '0;
      overrun  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      busy    <= (next_state != S_IDLE);
      if ((state == S_DONE) && (!rx_valid || rx_ready)) begin
        rx_data            <= shreg;
        flags_q.frame_err  <= fe_q;
        flags_q.parity_err <= pe_q;
        flags_q.break_det  <= !ones_q;
        rx_valid           <= 1'b1;
      end else begin
        if (state == S_DONE) overrun <= 1'b1;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: random and directed frames against a spec-level model.
module tb_uart_rx_cfg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [DIV_W-1:0]  baud_div;
  logic [3:0]        cfg_data_bits;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic              rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              parity_err;
  logic              break_det;
  logic              overrun;
  logic              busy;

  always #10 clk = ~clk;

  uart_rx_cfg #(.DATA_W(DATA_W), .DIV_W(DIV_W), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .baud_div      (baud_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_err     (frame_err),
    .parity_err    (parity_err),
    .break_det     (break_det),
    .overrun       (overrun),
    .busy          (busy)
  );

  typedef struct {
    int data;
    int fe;
    int pe;
    int bk;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   total = 0;
  int   bad = 0;
  int   ovr_cnt = 0;
  int   valid_cycles = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff_bits(input int cfg);
    if (cfg < 5) return 5;
    if (cfg > int'(DATA_W)) return int'(DATA_W);
    return cfg;
  endfunction

  // Expected word from the bit values placed on the line.
  function automatic exp_t model(input int data, input int n, input int par,
                                 input int pbit, input int s0, input int s1, input int two);
    exp_t e;
    int   d;
    int   par_on;
    d = data & ((1 << n) - 1);
    par_on = (par == 1 || par == 2) ? 1 : 0;
    e.data = d;
    e.pe = (par_on != 0 && (($countones(d) + pbit) % 2) != ((par == 2) ? 1 : 0)) ? 1 : 0;
    e.fe = (s0 == 0 || (two != 0 && s1 == 0)) ? 1 : 0;
    e.bk = (d == 0 && (par_on == 0 || pbit == 0) && s0 == 0 && (two == 0 || s1 == 0)) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (overrun) ovr_cnt++;
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word actual=0x%0h required=none", rx_data);
        end else begin
          got = sb.pop_front();
          check("rx_data", int'(rx_data), got.data);
          check("frame_err", int'(frame_err), got.fe);
          check("parity_err", int'(parity_err), got.pe);
          check("break_det", int'(break_det), got.bk);
        end
      end
    end
  end

  task automatic drive_seg(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input bit noisy, input int len);
    for (int s = 0; s < 16; s++) begin
      drive_seg((noisy && (s == 7 || s == 10)) ? ~b : b, len);
    end
  endtask

  // Final stop bit; optionally raises rx_ready in the cycle the receiver completes the frame.
  task automatic drive_last(input logic b, input int len, input bit rdy);
    for (int s = 0; s < 16; s++) begin
      if (rdy && s == 12) begin
        drive_seg(b, 3);
        rx_ready = 1'b1;
        drive_seg(b, len - 3);
      end else begin
        drive_seg(b, len);
      end
    end
  endtask

  task automatic send_frame(input int data, input int cfg_bits, input int par, input int two,
                            input int div, input bit bad_par, input bit bad_stop,
                            input bit noisy, input bit push, input bit rdy_done);
    int n;
    int len;
    int d;
    int pbit;
    int s0;
    n    = eff_bits(cfg_bits);
    len  = div + 1;
    d    = data & ((1 << n) - 1);
    pbit = (($countones(d) + ((par == 2) ? 1 : 0)) % 2) ^ (bad_par ? 1 : 0);
    s0   = bad_stop ? 0 : 1;
    baud_div      = DIV_W'(div);
    cfg_data_bits = 4'(cfg_bits);
    cfg_parity    = 2'(par);
    cfg_stop2     = (two != 0);
    if (push) sb.push_back(model(data, n, par, pbit, s0, 1, two));
    drive_bit(1'b0, 1'b0, len);
    baud_div      = DIV_W'($urandom_range(0, 400));
    cfg_data_bits = 4'($urandom_range(0, 15));
    cfg_parity    = 2'($urandom_range(0, 3));
    cfg_stop2     = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) drive_bit(d[i], noisy, len);
    if (par == 1 || par == 2) drive_bit(pbit[0], 1'b0, len);
    if (two != 0) begin
      drive_bit(s0[0], 1'b0, len);
      drive_last(1'b1, len, rdy_done);
    end else begin
      drive_last(s0[0], len, rdy_done);
    end
    drive_seg(1'b1, 32 * len);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, int'(rx_data), 0);
    check({tag, "_rx_valid"}, int'(rx_valid), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_parity_err"}, int'(parity_err), 0);
    check({tag, "_break_det"}, int'(break_det), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #1_600_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int o0;
    int wait_cnt;
    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    baud_div = 16'd26;
    cfg_data_bits = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_seg(1'b1, 20);

    // 8N1 at the nominal 115200 divisor.
    v0 = valid_cycles;
    send_frame(32'hA5, 8, 0, 0, 26, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_valid_cycles", valid_cycles - v0, 1);

    // 7E2 with wrong then correct parity.
    send_frame(32'h35, 7, 1, 1, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(32'h35, 7, 1, 1, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Short glitch must be rejected as a false start.
    v0 = valid_cycles;
    baud_div = 16'd7;
    drive_seg(1'b0, 3 * 8);
    drive_seg(1'b1, 32 * 8);
    @(negedge clk);
    check("glitch_busy", int'(busy), 0);
    check("glitch_valid_cycles", valid_cycles - v0, 0);

    // Two corrupted samples per data bit are outvoted.
    send_frame(32'h3C, 8, 0, 0, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Overrun: second word dropped while the first is held.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(32'h11, 8, 0, 0, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(32'h22, 8, 0, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("overrun_count", ovr_cnt - o0, 1);
    check("overrun_hold", int'(rx_data), 32'h11);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    drive_seg(1'b1, 8);

    // Accept held word in the completion cycle of the next one: no overrun.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(32'h11, 8, 0, 0, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(32'h22, 8, 0, 0, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("reload_no_overrun", ovr_cnt - o0, 0);
    check("reload_drained", sb.size(), 0);

    // Break on 8O1: line held low for 20 bit times.
    baud_div = 16'd7;
    cfg_data_bits = 4'd8;
    cfg_parity = 2'b10;
    cfg_stop2 = 1'b0;
    sb.push_back(model(0, 8, 2, 0, 0, 0, 0));
    drive_seg(1'b0, 20 * 16 * 8);
    @(negedge clk);
    check("break_idle_busy", int'(busy), 0);
    check("break_drained", sb.size(), 0);
    @(posedge clk);
    #1;
    drive_seg(1'b1, 32 * 8);

    // Reset mid-frame with a word held: everything cleared, next frame clean.
    rx_ready = 1'b0;
    send_frame(32'h5A, 8, 0, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    baud_div = 16'd7;
    cfg_data_bits = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    drive_bit(1'b0, 1'b0, 8);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 8);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx_ready = 1'b1;
    drive_seg(1'b1, 32 * 8);
    check("midreset_valid", int'(rx_valid), 0);
    send_frame(32'hC3, 8, 0, 0, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomised configurations and payloads.
    for (int k = 0; k < 16; k++) begin
      int par;
      par = int'($urandom_range(0, 3));
      send_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), par,
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1), 1'b1, 1'b0);
    end

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 2000) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("final_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
